mem_write_checker: RTL and testbench

Synthesizable, self-checking monitor that sits beside the MIPS `top` in simulation and FPGA bring-up. It observes the core's data-memory write port (`memwrite`, `aluout`, `writedata`) and compares every store against a preloaded queue of expected writes. A per-write watchdog detects a stalled program. It reports registered pass/fail status, which replaces a single hard-wired "writedata == 21" check with a parametrised, multi-write, timeout-aware check.

---
 rtl/mem_write_checker_pkg.sv | 17 +
 rtl/mem_write_checker_chk_sync_fifo.sv | 53 +++++
 rtl/mem_write_checker.sv | 149 ++++++++++++++
 tb/tb_mem_write_checker.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_write_checker_pkg.sv
// mem_write_checker_pkg: checker state encoding and fail_code values shared by
// the checker top and its bench.
package mem_write_checker_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } chk_state_t;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_MISMATCH = 2'd1;
    localparam logic [1:0] FC_TIMEOUT  = 2'd2;
    localparam logic [1:0] FC_EMPTY    = 2'd3;

endpackage

// File: rtl/mem_write_checker_chk_sync_fifo.sv
// chk_sync_fifo: DEPTH x W first-word-fall-through synchronous FIFO with
// synchronous flush. Pointers carry one extra wrap bit so full and empty are
// distinguishable when the index bits match.
module chk_sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    // Pointer update with flush overriding push/pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/mem_write_checker.sv
// mem_write_checker: compares each data-memory store of the core against a
// preloaded queue of expected (address, data) pairs, with a per-store watchdog.
// Build option: define MEM_WRITE_CHECKER_ADDR_CMP_EN to also require the store
// address to match; otherwise only data is compared.
module mem_write_checker
    import mem_write_checker_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned TIMEOUT_W = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      exp_valid,
    output logic                      exp_ready,
    input  logic [ADDR_W-1:0]         exp_addr,
    input  logic [DATA_W-1:0]         exp_data,
    input  logic                      start,
    input  logic [TIMEOUT_W-1:0]      timeout_cycles,
    input  logic                      memwrite,
    input  logic [ADDR_W-1:0]         aluout,
    input  logic [DATA_W-1:0]         writedata,
    output logic                      done,
    output logic                      pass,
    output logic [1:0]                fail_code,
    output logic [$clog2(DEPTH):0]    checked,
    output logic [DATA_W-1:0]         bad_data
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

`ifdef MEM_WRITE_CHECKER_ADDR_CMP_EN
    localparam logic ADDR_DONT_CARE = 1'b0;
`else
    localparam logic ADDR_DONT_CARE = 1'b1;
`endif

    chk_state_t              state;
    logic [TIMEOUT_W-1:0]    wdog;
    logic [TIMEOUT_W-1:0]    wdog_inc;

    logic                    q_push;
    logic                    q_pop;
    logic                    q_full;
    logic                    q_empty;
    logic [CW-1:0]           q_count;
    logic [ADDR_W+DATA_W-1:0] q_head;
    logic [ADDR_W-1:0]       head_addr;
    logic [DATA_W-1:0]       head_data;
    logic                    store_match;

    assign exp_ready = (state == ST_LOAD) && !q_full;
    assign q_push    = !clear && (state == ST_LOAD) && exp_valid && !q_full;
    assign q_pop     = !clear && (state == ST_RUN) && memwrite;

    assign head_addr = q_head[ADDR_W+DATA_W-1:DATA_W];
    assign head_data = q_head[DATA_W-1:0];

    // Address term is forced true when address comparison is compiled out.
    assign store_match = (writedata == head_data) &&
                         ((aluout == head_addr) || ADDR_DONT_CARE);

    assign wdog_inc = (wdog == '1) ? wdog : wdog + 1'b1;

    chk_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (ADDR_W + DATA_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (clear),
        .push  (q_push),
        .pop   (q_pop),
        .din   ({exp_addr, exp_data}),
        .dout  (q_head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    // Checker FSM, watchdog and registered result outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_LOAD;
            wdog      <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_code <= FC_NONE;
            checked   <= '0;
            bad_data  <= '0;
        end else if (clear) begin
            state     <= ST_LOAD;
            wdog      <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_code <= FC_NONE;
            checked   <= '0;
            bad_data  <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (start) begin
                        wdog <= '0;
                        // A push in the start cycle counts toward the run.
                        if (q_empty && !q_push) begin
                            state     <= ST_FAIL;
                            done      <= 1'b1;
                            fail_code <= FC_EMPTY;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (memwrite) begin
                        // A store always wins over a coincident watchdog expiry.
                        if (store_match) begin
                            checked <= checked + 1'b1;
                            wdog    <= '0;
                            if (q_count == CW'(1)) begin
                                state <= ST_PASS;
                                done  <= 1'b1;
                                pass  <= 1'b1;
                            end
                        end else begin
                            state     <= ST_FAIL;
                            done      <= 1'b1;
                            fail_code <= FC_MISMATCH;
                            bad_data  <= writedata;
                        end
                    end else begin
                        wdog <= wdog_inc;
                        if ((timeout_cycles != '0) && (wdog_inc >= timeout_cycles)) begin
                            state     <= ST_FAIL;
                            done      <= 1'b1;
                            fail_code <= FC_TIMEOUT;
                        end
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_write_checker.sv
// tb_mem_write_checker: directed-vector bench for mem_write_checker at the
// default parameters (DEPTH=8, 32-bit data/address, 16-bit watchdog).
module tb_mem_write_checker;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        exp_valid;
    logic        exp_ready;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic        start;
    logic [15:0] timeout_cycles;
    logic        memwrite;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic        done;
    logic        pass;
    logic [1:0]  fail_code;
    logic [3:0]  checked;
    logic [31:0] bad_data;

    int checks = 0;
    int errors = 0;
    int n;

    mem_write_checker #(
        .DATA_W    (32),
        .ADDR_W    (32),
        .DEPTH     (8),
        .TIMEOUT_W (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .clear          (clear),
        .exp_valid      (exp_valid),
        .exp_ready      (exp_ready),
        .exp_addr       (exp_addr),
        .exp_data       (exp_data),
        .start          (start),
        .timeout_cycles (timeout_cycles),
        .memwrite       (memwrite),
        .aluout         (aluout),
        .writedata      (writedata),
        .done           (done),
        .pass           (pass),
        .fail_code      (fail_code),
        .checked        (checked),
        .bad_data       (bad_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        exp_valid = 1'b1;
        exp_addr  = a;
        exp_data  = d;
        step();
        exp_valid = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        aluout    = a;
        writedata = d;
        step();
        memwrite  = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".exp_ready"}, 64'(exp_ready), 64'd1);
        check({tag, ".done"},      64'(done),      64'd0);
        check({tag, ".pass"},      64'(pass),      64'd0);
        check({tag, ".fail_code"}, 64'(fail_code), 64'd0);
        check({tag, ".checked"},   64'(checked),   64'd0);
        check({tag, ".bad_data"},  64'(bad_data),  64'd0);
    endtask

    initial begin
        reset = 1'b0; clear = 1'b0; exp_valid = 1'b0; exp_addr = '0; exp_data = '0;
        start = 1'b0; timeout_cycles = '0; memwrite = 1'b0; aluout = '0; writedata = '0;
        step();
        step();
        check_idle("reset");
        reset = 1'b1;
        step();

        // Single store matching the queued (0x54, 21).
        push(32'h54, 32'd21);
        go();
        check("t1.ready_in_run", 64'(exp_ready), 64'd0);
        check("t1.done_before",  64'(done),      64'd0);
        store(32'h54, 32'd21);
        check("t1.pass",    64'(pass),      64'd1);
        check("t1.done",    64'(done),      64'd1);
        check("t1.checked", 64'(checked),   64'd1);
        check("t1.code",    64'(fail_code), 64'd0);
        do_clear();
        check_idle("t1.clear");

        // Third store carries wrong data.
        push(32'h10, 32'd1);
        push(32'h14, 32'd2);
        push(32'h18, 32'd3);
        go();
        store(32'h10, 32'd1);
        store(32'h14, 32'd2);
        check("t2.checked2", 64'(checked), 64'd2);
        check("t2.done0",    64'(done),    64'd0);
        store(32'h18, 32'd20);
        check("t2.done",     64'(done),      64'd1);
        check("t2.pass",     64'(pass),      64'd0);
        check("t2.code",     64'(fail_code), 64'd1);
        check("t2.checked",  64'(checked),   64'd2);
        check("t2.bad_data", 64'(bad_data),  64'd20);
        store(32'h1c, 32'd99);
        check("t2.sticky_bad", 64'(bad_data),  64'd20);
        check("t2.sticky_code",64'(fail_code), 64'd1);
        do_clear();

        // Watchdog of 10 idle cycles after RUN entry.
        timeout_cycles = 16'd10;
        push(32'h54, 32'd21);
        go();
        n = 0;
        while (!done && n < 50) begin
            step();
            n++;
        end
        check("t3.cycles", 64'(n),         64'd10);
        check("t3.code",   64'(fail_code), 64'd2);
        check("t3.pass",   64'(pass),      64'd0);
        do_clear();

        // A store in the expiry cycle beats the timeout.
        timeout_cycles = 16'd3;
        push(32'h20, 32'd5);
        push(32'h24, 32'd6);
        go();
        step();
        step();
        store(32'h20, 32'd5);
        check("t3b.checked", 64'(checked), 64'd1);
        check("t3b.done",    64'(done),    64'd0);
        timeout_cycles = 16'd0;
        do_clear();

        // Start with nothing queued.
        go();
        check("t4.done", 64'(done),      64'd1);
        check("t4.code", 64'(fail_code), 64'd3);
        check("t4.pass", 64'(pass),      64'd0);
        do_clear();

        // Fill the queue to DEPTH.
        for (int i = 0; i < 8; i++) begin
            push(32'(i * 4), 32'(i));
            check($sformatf("t4.ready%0d", i), 64'(exp_ready), (i == 7) ? 64'd0 : 64'd1);
        end
        do_clear();
        check("t4.clr_ready",   64'(exp_ready), 64'd1);
        check("t4.clr_checked", 64'(checked),   64'd0);

        // Address mismatch with matching data.
        push(32'h54, 32'd21);
        go();
        store(32'h58, 32'd21);
        check("t5.done", 64'(done), 64'd1);
`ifdef MEM_WRITE_CHECKER_ADDR_CMP_EN
        check("t5.pass", 64'(pass),      64'd0);
        check("t5.code", 64'(fail_code), 64'd1);
`else
        check("t5.pass", 64'(pass),      64'd1);
        check("t5.code", 64'(fail_code), 64'd0);
`endif
        do_clear();

        // Asynchronous reset mid-run.
        push(32'h30, 32'd7);
        push(32'h34, 32'd8);
        push(32'h38, 32'd9);
        go();
        store(32'h30, 32'd7);
        store(32'h34, 32'd8);
        check("t6.checked2", 64'(checked), 64'd2);
        reset = 1'b0;
        #1;
        check_idle("t6.reset");
        reset = 1'b1;
        step();
        store(32'h38, 32'd9);
        check("t6.load_ignores_store", 64'(checked), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
